// File: rtl/snitch_muldiv_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : snitch_muldiv_arb_pkg
// Brief  : Shared types and constants for the mul/div share arbiter.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package snitch_muldiv_arb_pkg;

  localparam int PerfCntW  = 16;
  localparam int MaxDataW  = 64;
  localparam int MaxAccIdW = 16;

  // Sized for the widest supported configuration of the shared-unit interface.
  typedef struct packed {
    logic [31:0]          op;
    logic [MaxDataW-1:0]  arga;
    logic [MaxDataW-1:0]  argb;
    logic [MaxAccIdW-1:0] id;
  } acc_req_t;

  typedef struct packed {
    logic [MaxDataW-1:0]  data;
    logic [MaxAccIdW-1:0] id;
    logic                 error;
  } acc_rsp_t;

endpackage
`default_nettype wire

// File: rtl/snitch_muldiv_arb_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : snitch_muldiv_arb_rr
// Brief  : Round-robin grant encoder with a lock that holds the grant while
//          the downstream port back-pressures.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module snitch_muldiv_arb_rr
  import snitch_muldiv_arb_pkg::*;
#(
  parameter  int NrCores = 4,
  localparam int IdxW    = $clog2(NrCores)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NrCores-1:0] i_elig,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [IdxW-1:0]    o_grant
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] r_lock_idx;
  logic            r_lock;
  logic [IdxW-1:0] w_hi_idx;
  logic [IdxW-1:0] w_lo_idx;
  logic            w_hi_found;
  logic            w_lo_found;

  // Lowest eligible index at/above the pointer wins, else lowest below it.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int i = NrCores - 1; i >= 0; i--) begin
      if (i_elig[i]) begin
        if (IdxW'(i) >= r_ptr) begin
          w_hi_idx   = IdxW'(i);
          w_hi_found = 1'b1;
        end else begin
          w_lo_idx   = IdxW'(i);
          w_lo_found = 1'b1;
        end
      end
    end
  end

  assign o_valid = r_lock ? i_elig[r_lock_idx] : (w_hi_found | w_lo_found);
  assign o_grant = r_lock ? r_lock_idx : (w_hi_found ? w_hi_idx : w_lo_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_lock     <= o_valid & ~i_ready;
      r_lock_idx <= o_grant;
      if (o_valid & i_ready) begin
        r_ptr <= (o_grant == IdxW'(NrCores - 1)) ? '0 : o_grant + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snitch_muldiv_share_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : snitch_muldiv_share_arb
// Brief  : Shares one mul/div accelerator port among NrCores cores with
//          bounded outstanding ops. SNITCH_MULDIV_ARB_PERF_EN adds stall counters.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module snitch_muldiv_share_arb
  import snitch_muldiv_arb_pkg::*;
#(
  parameter  int NrCores   = 4,
  parameter  int IdWidth   = 5,
  parameter  int DataWidth = 32,
  parameter  int MaxOutst  = 2,
  localparam int CoreIdxW  = $clog2(NrCores)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NrCores*32-1:0]         core_qop_i,
  input  logic [NrCores*IdWidth-1:0]    core_qid_i,
  input  logic [NrCores*DataWidth-1:0]  core_qarga_i,
  input  logic [NrCores*DataWidth-1:0]  core_qargb_i,
  input  logic [NrCores-1:0]            core_qvalid_i,
  output logic [NrCores-1:0]            core_qready_o,
  output logic [NrCores*DataWidth-1:0]  core_pdata_o,
  output logic [NrCores*IdWidth-1:0]    core_pid_o,
  output logic [NrCores-1:0]            core_perror_o,
  output logic [NrCores-1:0]            core_pvalid_o,
  input  logic [NrCores-1:0]            core_pready_i,
  output logic [31:0]                   acc_qop_o,
  output logic [DataWidth-1:0]          acc_qarga_o,
  output logic [DataWidth-1:0]          acc_qargb_o,
  output logic [CoreIdxW+IdWidth-1:0]   acc_qid_o,
  output logic                          acc_qvalid_o,
  input  logic                          acc_qready_i,
  input  logic [DataWidth-1:0]          acc_pdata_i,
  input  logic [CoreIdxW+IdWidth-1:0]   acc_pid_i,
  input  logic                          acc_perror_i,
  input  logic                          acc_pvalid_i,
  output logic                          acc_pready_o,
`ifdef SNITCH_MULDIV_ARB_PERF_EN
  output logic [NrCores*PerfCntW-1:0]   perf_stall_cnt_o,
`endif
  output logic                          bad_rsp_o
);

  localparam int CntW = $clog2(MaxOutst + 1);

  logic [NrCores-1:0]  w_elig;
  logic [NrCores-1:0]  w_inc;
  logic [NrCores-1:0]  w_dec;
  logic [NrCores-1:0]  w_illegal;
  logic [NrCores-1:0]  w_pvalid;
  logic [CntW-1:0]     r_cnt [NrCores];
  logic                w_qvalid;
  logic [CoreIdxW-1:0] w_grant;
  logic [CoreIdxW-1:0] w_ridx;
  logic                w_hit;
  logic                w_prdy;
  logic                w_phs;
  logic                r_bad;

  snitch_muldiv_arb_rr #(
    .NrCores (NrCores)
  ) u_rr (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_elig  (w_elig),
    .i_ready (acc_qready_i),
    .o_valid (w_qvalid),
    .o_grant (w_grant)
  );

  assign acc_qvalid_o = w_qvalid;
  assign acc_qop_o    = core_qop_i[int'(w_grant)*32 +: 32];
  assign acc_qarga_o  = core_qarga_i[int'(w_grant)*DataWidth +: DataWidth];
  assign acc_qargb_o  = core_qargb_i[int'(w_grant)*DataWidth +: DataWidth];
  assign acc_qid_o    = {w_grant, core_qid_i[int'(w_grant)*IdWidth +: IdWidth]};

  // An index beyond NrCores-1 matches no core: the response is accepted and dropped.
  assign w_ridx = acc_pid_i[IdWidth +: CoreIdxW];

  always_comb begin
    w_pvalid = '0;
    w_prdy   = 1'b1;
    w_hit    = 1'b0;
    for (int i = 0; i < NrCores; i++) begin
      if (w_ridx == CoreIdxW'(i)) begin
        w_pvalid[i] = acc_pvalid_i;
        w_prdy      = core_pready_i[i];
        w_hit       = 1'b1;
      end
    end
  end

  assign acc_pready_o  = w_prdy;
  assign w_phs         = acc_pvalid_i & w_prdy;
  assign core_pvalid_o = w_pvalid;
  assign core_pdata_o  = {NrCores{acc_pdata_i}};
  assign core_pid_o    = {NrCores{acc_pid_i[IdWidth-1:0]}};
  assign core_perror_o = {NrCores{acc_perror_i}};

  for (genvar i = 0; i < NrCores; i++) begin : g_core
    assign w_elig[i]        = core_qvalid_i[i] & (r_cnt[i] < CntW'(MaxOutst));
    assign core_qready_o[i] = w_qvalid & acc_qready_i & (w_grant == CoreIdxW'(i));
    assign w_inc[i]         = core_qready_o[i];
    assign w_dec[i]         = w_phs & w_hit & (w_ridx == CoreIdxW'(i));
    assign w_illegal[i]     = w_dec[i] & ~w_inc[i] & (r_cnt[i] == '0);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt[i] <= '0;
      end else if (w_inc[i] & ~w_dec[i]) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end else if (w_dec[i] & ~w_inc[i] & (r_cnt[i] != '0)) begin
        r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end

`ifdef SNITCH_MULDIV_ARB_PERF_EN
    logic [PerfCntW-1:0] r_stall;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_stall <= '0;
      end else if (core_qvalid_i[i] & ~core_qready_o[i] & ~(&r_stall)) begin
        r_stall <= r_stall + 1'b1;
      end
    end
    assign perf_stall_cnt_o[i*PerfCntW +: PerfCntW] = r_stall;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bad <= 1'b0;
    end else if ((w_phs & ~w_hit) | (|w_illegal)) begin
      r_bad <= 1'b1;
    end
  end

  assign bad_rsp_o = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_snitch_muldiv_share_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_snitch_muldiv_share_arb
// Brief  : Self-checking bench: vector table, directed corner sequences and a
//          randomized run against a queue-based reference model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_snitch_muldiv_share_arb;

  localparam int NC = 4;
  localparam int IW = 5;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int CW = 2;

  logic                clk = 1'b0;
  logic                rst_i;
  logic [NC*32-1:0]    core_qop_i;
  logic [NC*IW-1:0]    core_qid_i;
  logic [NC*DW-1:0]    core_qarga_i;
  logic [NC*DW-1:0]    core_qargb_i;
  logic [NC-1:0]       core_qvalid_i;
  logic [NC-1:0]       core_qready_o;
  logic [NC*DW-1:0]    core_pdata_o;
  logic [NC*IW-1:0]    core_pid_o;
  logic [NC-1:0]       core_perror_o;
  logic [NC-1:0]       core_pvalid_o;
  logic [NC-1:0]       core_pready_i;
  logic [31:0]         acc_qop_o;
  logic [DW-1:0]       acc_qarga_o;
  logic [DW-1:0]       acc_qargb_o;
  logic [CW+IW-1:0]    acc_qid_o;
  logic                acc_qvalid_o;
  logic                acc_qready_i;
  logic [DW-1:0]       acc_pdata_i;
  logic [CW+IW-1:0]    acc_pid_i;
  logic                acc_perror_i;
  logic                acc_pvalid_i;
  logic                acc_pready_o;
  logic                bad_rsp_o;
`ifdef SNITCH_MULDIV_ARB_PERF_EN
  logic [NC*16-1:0]    perf_stall_cnt_o;
`endif

  always #5 clk = ~clk;

  snitch_muldiv_share_arb #(
    .NrCores(NC), .IdWidth(IW), .DataWidth(DW), .MaxOutst(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_qop_i(core_qop_i), .core_qid_i(core_qid_i),
    .core_qarga_i(core_qarga_i), .core_qargb_i(core_qargb_i),
    .core_qvalid_i(core_qvalid_i), .core_qready_o(core_qready_o),
    .core_pdata_o(core_pdata_o), .core_pid_o(core_pid_o),
    .core_perror_o(core_perror_o), .core_pvalid_o(core_pvalid_o),
    .core_pready_i(core_pready_i),
    .acc_qop_o(acc_qop_o), .acc_qarga_o(acc_qarga_o), .acc_qargb_o(acc_qargb_o),
    .acc_qid_o(acc_qid_o), .acc_qvalid_o(acc_qvalid_o), .acc_qready_i(acc_qready_i),
    .acc_pdata_i(acc_pdata_i), .acc_pid_i(acc_pid_i), .acc_perror_i(acc_perror_i),
    .acc_pvalid_i(acc_pvalid_i), .acc_pready_o(acc_pready_o),
`ifdef SNITCH_MULDIV_ARB_PERF_EN
    .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
    .bad_rsp_o(bad_rsp_o)
  );

  int checks = 0;
  int errors = 0;

  logic        b_v  [NC];
  logic [31:0] b_op [NC];
  logic [4:0]  b_id [NC];
  logic [31:0] b_a  [NC];
  logic [31:0] b_b  [NC];

  typedef struct {
    logic [3:0] qv;  logic rdy; logic pv; logic [6:0] pid; logic [3:0] prdy;
    logic ev; logic [3:0] eqr; logic [6:0] eqid; logic [3:0] epv; logic epr;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cores();
    for (int i = 0; i < NC; i++) begin
      core_qvalid_i[i]          = b_v[i];
      core_qop_i[i*32 +: 32]    = b_op[i];
      core_qid_i[i*IW +: IW]    = b_id[i];
      core_qarga_i[i*DW +: DW]  = b_a[i];
      core_qargb_i[i*DW +: DW]  = b_b[i];
    end
  endtask

  task automatic set_valid(input logic [3:0] m);
    for (int i = 0; i < NC; i++) b_v[i] = m[i];
    drive_cores();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_i = 1'b1;
    for (int i = 0; i < NC; i++) begin
      b_v[i] = 1'b0; b_op[i] = 32'h100 + i; b_id[i] = 5'(10 + i);
      b_a[i] = 32'hA000 + i; b_b[i] = 32'hB000 + i;
    end
    drive_cores();
    acc_qready_i = 1'b0; core_pready_i = '0;
    acc_pvalid_i = 1'b0; acc_pid_i = '0; acc_pdata_i = '0; acc_perror_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // Reference model state
  int         m_ptr, m_lock, eg, c, ridx, rsp_k;
  int         m_cnt [NC];
  bit         m_bad, ev, qhs, phs, rsp_hold;
  bit         hold [NC];
  logic [6:0] pend_q [$];
  logic [3:0] eqr;

  initial begin
    rst_i = 1'b1;
    // Table: reset held high so every vector starts from the reset state.
    tbl[0] = '{4'b0000, 1'b1, 1'b0, 7'd0,  4'b0000, 1'b0, 4'b0000, 7'd0,   4'b0000, 1'b0};
    tbl[1] = '{4'b0101, 1'b1, 1'b0, 7'd0,  4'b0001, 1'b1, 4'b0001, 7'd10,  4'b0000, 1'b1};
    tbl[2] = '{4'b1100, 1'b1, 1'b0, 7'd64, 4'b0100, 1'b1, 4'b0100, 7'd76,  4'b0000, 1'b1};
    tbl[3] = '{4'b1000, 1'b0, 1'b0, 7'd96, 4'b0000, 1'b1, 4'b0000, 7'd109, 4'b0000, 1'b0};
    tbl[4] = '{4'b0000, 1'b1, 1'b1, 7'd39, 4'b0010, 1'b0, 4'b0000, 7'd0,   4'b0010, 1'b1};
    tbl[5] = '{4'b0010, 1'b1, 1'b1, 7'd98, 4'b0111, 1'b1, 4'b0010, 7'd43,  4'b1000, 1'b0};
    tbl[6] = '{4'b1111, 1'b0, 1'b1, 7'd1,  4'b1110, 1'b1, 4'b0000, 7'd10,  4'b0001, 1'b0};
    reset_dut();
    rst_i = 1'b1;
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      set_valid(tbl[t].qv);
      acc_qready_i = tbl[t].rdy; acc_pvalid_i = tbl[t].pv;
      acc_pid_i = tbl[t].pid; core_pready_i = tbl[t].prdy;
      #1;
      chk($sformatf("tbl%0d qvalid", t), acc_qvalid_o, tbl[t].ev);
      chk($sformatf("tbl%0d qready", t), core_qready_o, tbl[t].eqr);
      if (tbl[t].ev) begin
        chk($sformatf("tbl%0d qid", t), acc_qid_o, tbl[t].eqid);
        chk($sformatf("tbl%0d qop", t), acc_qop_o, 32'h100 + tbl[t].eqid[6:5]);
      end
      chk($sformatf("tbl%0d pvalid", t), core_pvalid_o, tbl[t].epv);
      chk($sformatf("tbl%0d pready", t), acc_pready_o, tbl[t].epr);
    end

    // Reset state
    reset_dut();
    #1;
    chk("rst qvalid", acc_qvalid_o, 0);
    chk("rst qready", core_qready_o, 0);
    chk("rst pvalid", core_pvalid_o, 0);
    chk("rst bad", bad_rsp_o, 0);

    // Cores 0 and 2: grant 0 then 2
    set_valid(4'b0101); acc_qready_i = 1'b1;
    #1; chk("rr c0 qid", acc_qid_o, 7'd10); chk("rr c0 qready", core_qready_o, 4'b0001);
    @(negedge clk); set_valid(4'b0100);
    #1; chk("rr c2 qid", acc_qid_o, 7'd76); chk("rr c2 qready", core_qready_o, 4'b0100);

    // Lock: core1 stalled 3 cycles, core0 joins but must wait
    @(negedge clk); set_valid(4'b0010); acc_qready_i = 1'b0;
    #1; chk("lock cyc0 qid", acc_qid_o, 7'd43);
    @(negedge clk); set_valid(4'b0011);
    #1; chk("lock cyc1 qid", acc_qid_o, 7'd43); chk("lock cyc1 qready", core_qready_o, 0);
    @(negedge clk);
    #1; chk("lock cyc2 qid", acc_qid_o, 7'd43);
    @(negedge clk); acc_qready_i = 1'b1;
    #1; chk("lock hs qid", acc_qid_o, 7'd43); chk("lock hs qready", core_qready_o, 4'b0010);
    @(negedge clk); set_valid(4'b0001);
    #1; chk("after lock qid", acc_qid_o, 7'd10); chk("after lock qready", core_qready_o, 4'b0001);

    // Outstanding limit on core 3
    reset_dut();
    set_valid(4'b1000); acc_qready_i = 1'b1;
    #1; chk("lim op1 qready", core_qready_o, 4'b1000);
    @(negedge clk); b_id[3] = 5'd14; drive_cores();
    #1; chk("lim op2 qready", core_qready_o, 4'b1000);
    @(negedge clk);
    #1; chk("lim op3 qready", core_qready_o, 0); chk("lim op3 qvalid", acc_qvalid_o, 0);
    @(negedge clk); acc_pvalid_i = 1'b1; acc_pid_i = 7'd109; core_pready_i = 4'b1000;
    #1; chk("lim rsp pready", acc_pready_o, 1); chk("lim rsp pvalid", core_pvalid_o, 4'b1000);
    chk("lim rsp qready", core_qready_o, 0);
    @(negedge clk); acc_pvalid_i = 1'b0;
    #1; chk("lim op3 granted", core_qready_o, 4'b1000); chk("lim op3 qid", acc_qid_o, {2'd3, 5'd14});

    // Response backpressure on core 1 with two ops outstanding
    reset_dut();
    set_valid(4'b0010); acc_qready_i = 1'b1;
    @(negedge clk); b_id[1] = 5'd4; drive_cores();
    @(negedge clk); acc_pvalid_i = 1'b1; acc_pid_i = 7'd39; core_pready_i = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bp pvalid", core_pvalid_o, 4'b0010); chk("bp pready", acc_pready_o, 0);
      chk("bp pid", core_pid_o[IW +: IW], 5'd7); chk("bp qready", core_qready_o, 0);
      @(negedge clk);
    end
    core_pready_i = 4'b0010;
    #1; chk("bp hs pready", acc_pready_o, 1); chk("bp hs qready", core_qready_o, 0);
    @(negedge clk); acc_pvalid_i = 1'b0;
    #1; chk("bp after qready", core_qready_o, 4'b0010);

    // Illegal response to an idle core
    reset_dut();
    acc_pvalid_i = 1'b1; acc_pid_i = 7'd67; core_pready_i = 4'b0100;
    #1; chk("bad pready", acc_pready_o, 1); chk("bad before", bad_rsp_o, 0);
    @(negedge clk); acc_pvalid_i = 1'b0;
    #1; chk("bad set", bad_rsp_o, 1);
    @(negedge clk); set_valid(4'b0100); acc_qready_i = 1'b1;
    #1; chk("bad sticky", bad_rsp_o, 1); chk("bad cnt kept 0", core_qready_o, 4'b0100);
    reset_dut();
    #1; chk("bad cleared", bad_rsp_o, 0);

`ifdef SNITCH_MULDIV_ARB_PERF_EN
    reset_dut();
    set_valid(4'b0001); acc_qready_i = 1'b0;
    repeat (5) @(negedge clk);
    #1; chk("perf core0", perf_stall_cnt_o[15:0], 16'd5); chk("perf core1", perf_stall_cnt_o[31:16], 16'd0);
`endif

    // Randomized run against the reference model
    reset_dut();
    m_ptr = 0; m_lock = -1; m_bad = 0; rsp_hold = 0; pend_q.delete();
    for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; hold[i] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc != 0) @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (!hold[i]) begin
          b_v[i] = ($urandom_range(0, 9) < 6);
          b_op[i] = $urandom; b_id[i] = 5'($urandom); b_a[i] = $urandom; b_b[i] = $urandom;
        end
      end
      drive_cores();
      acc_qready_i  = ($urandom_range(0, 9) < 7);
      core_pready_i = 4'($urandom);
      if (!rsp_hold) begin
        if (pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
          rsp_k = $urandom_range(0, pend_q.size() - 1);
          acc_pvalid_i = 1'b1; acc_pid_i = pend_q[rsp_k];
          acc_pdata_i = $urandom; acc_perror_i = 1'($urandom);
        end else begin
          acc_pvalid_i = 1'b0;
        end
      end
      #1;
      ev = 0; eg = 0;
      if (m_lock >= 0) begin
        eg = m_lock; ev = b_v[eg] && (m_cnt[eg] < MO);
      end else begin
        for (int k = 0; k < NC; k++) begin
          c = (m_ptr + k) % NC;
          if (!ev && b_v[c] && m_cnt[c] < MO) begin ev = 1; eg = c; end
        end
      end
      eqr = (ev && acc_qready_i) ? 4'(1 << eg) : 4'b0000;
      chk("rnd qvalid", acc_qvalid_o, ev);
      chk("rnd qready", core_qready_o, eqr);
      if (ev) begin
        chk("rnd qid", acc_qid_o, (eg << IW) | b_id[eg]);
        chk("rnd qop", acc_qop_o, b_op[eg]);
        chk("rnd qarga", acc_qarga_o, b_a[eg]);
        chk("rnd qargb", acc_qargb_o, b_b[eg]);
      end
      ridx = int'(acc_pid_i) >> IW;
      chk("rnd pvalid", core_pvalid_o, acc_pvalid_i ? 4'(1 << ridx) : 4'b0000);
      chk("rnd pready", acc_pready_o, core_pready_i[ridx]);
      if (acc_pvalid_i) begin
        chk("rnd pdata", core_pdata_o[ridx*DW +: DW], acc_pdata_i);
        chk("rnd pid", core_pid_o[ridx*IW +: IW], acc_pid_i[IW-1:0]);
        chk("rnd perror", core_perror_o[ridx], acc_perror_i);
      end
      chk("rnd bad", bad_rsp_o, m_bad);
      qhs = ev && acc_qready_i;
      phs = acc_pvalid_i && core_pready_i[ridx];
      if (qhs) begin
        m_cnt[eg]++; m_ptr = (eg + 1) % NC; m_lock = -1;
        pend_q.push_back(7'((eg << IW) | b_id[eg]));
      end else begin
        m_lock = ev ? eg : -1;
      end
      if (phs) begin
        if (qhs && eg == ridx) m_cnt[ridx]--;
        else if (m_cnt[ridx] == 0) m_bad = 1;
        else m_cnt[ridx]--;
        pend_q.delete(rsp_k);
      end
      rsp_hold = acc_pvalid_i && !phs;
      for (int i = 0; i < NC; i++) hold[i] = b_v[i] && !(qhs && eg == i);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
